serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial sequencer and two-port arbiter for a single external `Adder1bit` full-adder cell in the pseudoinverse datapath. Two requesters share one cell. The block grants one requester round-robin and latches its WIDTH-bit operands. It then walks the cell LSB-first, one bit per clock, feeding the registered carry back. It returns the sum or difference with carry and signed-overflow flags. The cell is purely combinational; this block owns all state.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 operation request, level, held until ack0
- a0, b0  in  WIDTH  requester 0 operands, sampled in grant cycle
- sub0  in  1  requester 0: 1 = a0−b0, 0 = a0+b0
- req1, a1, b1, sub1  in  1/WIDTH/WIDTH/1  same for requester 1
- ack0, ack1  out  1  one-cycle completion pulse to owning requester
- owner  out  1  index of current/last granted requester
- busy  out  1  high from grant cycle through last bit cycle
- done  out  1  one-cycle pulse, coincident with ack
- result  out  WIDTH  final sum/difference, held until next grant
- carry_out  out  1  final carry (for subtract: 1 = no borrow)
- overflow  out  1  two's-complement overflow of final operation
- add_a, add_b, add_cin  out  1  drive cell inputs A, B, Cin
- add_d, add_cout  in  1  cell outputs D, Cout (same-cycle combinational)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if any req, grant → RUN. Both requests: grant the one not served last. After reset, requester 0 has priority. Single request: grant it.
- Grant cycle:
  - latch a_sh = a_sel.
  - latch b_sh = sub_sel ? ~b_sel : b_sel.
  - set carry = sub_sel; clear count and result.
  - set owner; assert busy.
- RUN, each cycle:
  - add_a = a_sh[0], add_b = b_sh[0], add_cin = carry.
  - On edge: result ← {add_d, result[WIDTH-1:1]}; carry ← add_cout; a_sh, b_sh shift right; count++.
- Bit WIDTH−1 (last RUN cycle):
  - overflow ← add_cin XOR add_cout.
  - carry_out ← add_cout.
  - → DONE.
- DONE (one cycle): done=1, ack[owner]=1, busy=0; no arbitration this cycle → IDLE.
- Requester deasserts req on the cycle after ack. A req still high in the following IDLE cycle is a new request.
- Outside RUN, add_a, add_b, and add_cin are driven 0.
- Overflow and wrap are reported only through the flags; result is always modulo 2^WIDTH.

## Timing
- Grant cycle = G (IDLE with req). RUN cycles G+1 … G+WIDTH. DONE/ack/done at G+WIDTH+1.
- Result, carry_out, and overflow are valid from G+WIDTH+1 and stable until the next grant.
- Back-to-back: next grant earliest at G+WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- Operand or sub changes after G have no effect.
- Reset values: state IDLE, busy=0, done=0, ack0=ack1=0, owner=0, result=0, carry_out=0, overflow=0, add_*=0, round-robin pointer favours requester 0.
- rst mid-RUN or in DONE: on the next edge, abort to reset values. No ack is issued. A held req is re-arbitrated normally after rst drops.
- The cell's combinational path add_a/b/cin → add_d/cout must settle within one clock.

## Test plan
- WIDTH=8, req0, a0=0x5A, b0=0x33, sub0=0 → busy for 8 RUN cycles. ack0/done at G+9. result=0x8D, carry_out=0, overflow=1.
- req1, a1=0x10, b1=0x20, sub1=1 → result=0xF0, carry_out=0 (borrow), overflow=0, ack1 only, owner=1.
- Wrap: a0=0xFF, b0=0x01, add → result=0x00, carry_out=1, overflow=0. Then 0x80−0x01 → result=0x7F, carry_out=1, overflow=1.
- req0 and req1 held together from reset → grant order 0, 1, 0, 1. Each ack is exactly one cycle. Grants are WIDTH+2 cycles apart. The other requester's ack stays low.
- rst pulsed during RUN bit 3 → next cycle busy=0, result=0, no ack. After rst drops, a held req0 completes with the correct result at G+9.
- Bench model checks add_cin sequence against the reference carry chain each RUN cycle, and checks add_* = 0 when not busy.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial sequencer and round-robin two-port arbiter for one shared external
// full-adder cell: walks operands LSB-first and reports result, carry and overflow.
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sub0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub1,
    output logic             ack0,
    output logic             ack1,
    output logic             owner,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_d,
    input  logic             add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last;

    logic             grant_valid;
    logic             grant_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             sub_sel;
    logic             last_bit;

    // 'last' holds the most recently served requester; on contention the other one wins
    always_comb begin
        grant_valid = req0 | req1;
        grant_sel   = req1 & (~req0 | ~last);
        a_sel       = grant_sel ? a1 : a0;
        b_sel       = grant_sel ? b1 : b0;
        sub_sel     = grant_sel ? sub1 : sub0;
        last_bit    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state  <= RUN;
                        a_sh   <= a_sel;
                        // subtraction is a + ~b + 1, the +1 entering as the initial carry
                        b_sh   <= sub_sel ? ~b_sel : b_sel;
                        carry  <= sub_sel;
                        count  <= '0;
                        result <= '0;
                        owner  <= grant_sel;
                        last   <= grant_sel;
                    end
                end
                RUN: begin
                    result <= {add_d, result[WIDTH-1:1]};
                    carry  <= add_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        overflow  <= carry ^ add_cout;
                        carry_out <= add_cout;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign ack0    = done & ~owner;
    assign ack1    = done & owner;
    assign add_a   = busy & a_sh[0];
    assign add_b   = busy & b_sh[0];
    assign add_cin = busy & carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: models the adder cell, predicts results
// and per-bit carries from a scoreboard queue of issued operations.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, sub0, sub1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, owner, busy, done;
    logic [W-1:0] result;
    logic         carry_out, overflow;
    logic         add_a, add_b, add_cin, add_d, add_cout;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external Adder1bit cell
    assign add_d    = add_a ^ add_b ^ add_cin;
    assign add_cout = (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
        .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
        .ack0(ack0), .ack1(ack1), .owner(owner), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_d(add_d), .add_cout(add_cout)
    );

    typedef struct {
        logic         who;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } op_t;

    op_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  lastGrant = 0;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] effB(input op_t o);
        logic [W-1:0] nb;
        nb = o.sub ? ~o.b : o.b;
        return {1'b0, nb};
    endfunction

    function automatic logic [W:0] refSum(input op_t o);
        return {1'b0, o.a} + effB(o) + (W+1)'(o.sub);
    endfunction

    function automatic logic refOvf(input op_t o);
        logic [W:0] s;
        logic       sameSign;
        s = refSum(o);
        sameSign = (o.a[W-1] == o.b[W-1]);
        return (o.sub ? !sameSign : sameSign) && (s[W-1] != o.a[W-1]);
    endfunction

    function automatic logic refCin(input op_t o, input int i);
        logic [W:0] mask;
        logic [W:0] part;
        mask = (W+1)'((1 << i) - 1);
        part = ({1'b0, o.a} & mask) + (effB(o) & mask) + (W+1)'(o.sub);
        return part[i];
    endfunction

    task automatic applyStimulus(input op_t o);
        if (o.who) begin
            a1 = o.a; b1 = o.b; sub1 = o.sub;
        end else begin
            a0 = o.a; b0 = o.b; sub0 = o.sub;
        end
    endtask

    task automatic scramble(input logic who);
        if (who) begin
            a1 = W'($urandom); b1 = W'($urandom); sub1 = ~sub1;
        end else begin
            a0 = W'($urandom); b0 = W'($urandom); sub0 = ~sub0;
        end
    endtask

    task automatic runOne(input bit dropReq, input bit checkGap);
        op_t        e;
        logic [W:0] s;
        int         runIdx = 0;
        int         grantCyc = 0;
        bit         seenDone = 0;
        e = sb[0];
        s = refSum(e);
        for (int k = 0; k < 4 * W && !seenDone; k++) begin
            tick;
            if (busy) begin
                if (runIdx == 0) begin
                    grantCyc = cyc - 1;
                    if (checkGap) checkOutput("grant_gap", grantCyc - lastGrant, W + 2);
                    lastGrant = grantCyc;
                    checkOutput("owner", {31'd0, owner}, {31'd0, e.who});
                    scramble(e.who);
                end
                checkOutput($sformatf("cin_bit%0d", runIdx), {31'd0, add_cin}, {31'd0, refCin(e, runIdx)});
                runIdx++;
            end else begin
                checkOutput("idle_add", {29'd0, add_a, add_b, add_cin}, 32'd0);
                if (done) begin
                    seenDone = 1;
                    checkOutput("run_len", runIdx, W);
                    checkOutput("done_cycle", cyc - grantCyc, W + 1);
                    checkOutput("ack", {30'd0, ack1, ack0}, e.who ? 32'd2 : 32'd1);
                    checkOutput("result", {24'd0, result}, {24'd0, s[W-1:0]});
                    checkOutput("carry_out", {31'd0, carry_out}, {31'd0, s[W]});
                    checkOutput("overflow", {31'd0, overflow}, {31'd0, refOvf(e)});
                    void'(sb.pop_front());
                    if (dropReq) begin
                        req0 = 1'b0;
                        req1 = 1'b0;
                    end
                end
            end
        end
        checkOutput("done_seen", {31'd0, seenDone}, 32'd1);
        tick;
        checkOutput("ack_pulse", {29'd0, done, ack1, ack0}, 32'd0);
        checkOutput("result_hold", {24'd0, result}, {24'd0, s[W-1:0]});
        checkOutput("idle_add_post", {29'd0, add_a, add_b, add_cin}, 32'd0);
        if (sb.size() > 0) applyStimulus(sb[0]);
    endtask

    initial begin
        int runIdx;
        bit hitBit3;
        rst = 1'b1; req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) tick;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done_ack", {29'd0, done, ack1, ack0}, 32'd0);
        checkOutput("rst_owner", {31'd0, owner}, 32'd0);
        checkOutput("rst_result", {24'd0, result}, 32'd0);
        checkOutput("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
        checkOutput("rst_add", {29'd0, add_a, add_b, add_cin}, 32'd0);
        rst = 1'b0;
        tick;

        // Basic add, subtract with borrow, and the two wrap cases
        sb.push_back('{who: 1'b0, a: 8'h5A, b: 8'h33, sub: 1'b0});
        applyStimulus(sb[0]); req0 = 1'b1; runOne(1, 0);
        sb.push_back('{who: 1'b1, a: 8'h10, b: 8'h20, sub: 1'b1});
        applyStimulus(sb[0]); req1 = 1'b1; runOne(1, 0);
        sb.push_back('{who: 1'b0, a: 8'hFF, b: 8'h01, sub: 1'b0});
        applyStimulus(sb[0]); req0 = 1'b1; runOne(1, 0);
        sb.push_back('{who: 1'b0, a: 8'h80, b: 8'h01, sub: 1'b1});
        applyStimulus(sb[0]); req0 = 1'b1; runOne(1, 0);

        // Both requests held from reset: expect alternating grants, W+2 apart
        rst = 1'b1; tick; tick; rst = 1'b0;
        sb.push_back('{who: 1'b0, a: 8'h12, b: 8'h34, sub: 1'b0});
        sb.push_back('{who: 1'b1, a: 8'h7F, b: 8'h01, sub: 1'b0});
        sb.push_back('{who: 1'b0, a: 8'h01, b: 8'h02, sub: 1'b1});
        sb.push_back('{who: 1'b1, a: 8'hC8, b: 8'h9C, sub: 1'b1});
        applyStimulus(sb[0]); applyStimulus(sb[1]);
        req0 = 1'b1; req1 = 1'b1;
        runOne(0, 0); runOne(0, 1); runOne(0, 1); runOne(1, 1);

        // Reset during bit 3 of a run, then the held request completes afresh
        tick;
        sb.push_back('{who: 1'b0, a: 8'h5A, b: 8'h33, sub: 1'b0});
        applyStimulus(sb[0]); req0 = 1'b1;
        runIdx = 0; hitBit3 = 0;
        for (int k = 0; k < 4 * W && !hitBit3; k++) begin
            tick;
            if (busy) begin
                if (runIdx == 3) begin
                    hitBit3 = 1;
                    rst = 1'b1;
                end
                runIdx++;
            end
        end
        checkOutput("rst_mid_reached", {31'd0, hitBit3}, 32'd1);
        tick;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_result", {24'd0, result}, 32'd0);
        checkOutput("abort_ack", {29'd0, done, ack1, ack0}, 32'd0);
        applyStimulus(sb[0]);
        rst = 1'b0;
        runOne(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
